// File: rtl/hazard_scoreboard_ctrl.sv
// Decode-stage issue controller: per-register in-flight write scoreboard, RAW/saturation stall, branch squash.
// Optional macro WB_BYPASS_EN: a final writeback clears the hazard in the same cycle it arrives.
module hazard_scoreboard_ctrl #(
    parameter int REG_ADDR_W   = 5,
    parameter int NREGS        = 32,
    parameter int CNT_W        = 2,
    parameter int FLUSH_CYCLES = 2,
    parameter int PERF_W       = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid_i,
    input  logic [REG_ADDR_W-1:0] id_rs0_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic                  id_uses_rs0_i,
    input  logic                  id_uses_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rd_i,
    input  logic                  id_rf_we_i,
    input  logic                  wb_rf_we_i,
    input  logic [REG_ADDR_W-1:0] wb_waddr_i,
    input  logic                  ex_br_taken_i,
    output logic                  issue_o,
    output logic                  stall_o,
    output logic                  flush_o,
    output logic                  sb_err_o,
    output logic [PERF_W-1:0]     stall_cycles_o
);

    localparam int FC_W = $clog2(FLUSH_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic {
        ST_RUN,
        ST_FLUSH
    } state_e;

    state_e            state_q;
    logic [FC_W-1:0]   fc_q;
    logic [CNT_W-1:0]  cnt_q [NREGS];
    logic [CNT_W-1:0]  cnt_d [NREGS];
    logic              sb_err_q;
    logic              sb_err_d;
    logic [PERF_W-1:0] stall_cycles_q;
    logic [PERF_W-1:0] stall_cycles_d;

    logic wb_clears_rs0;
    logic wb_clears_rs1;
    logic busy_rs0;
    logic busy_rs1;
    logic rd_full;
    logic haz;
    logic inc;
    logic dec;

    always_comb begin
`ifdef WB_BYPASS_EN
        wb_clears_rs0 = wb_rf_we_i && (wb_waddr_i == id_rs0_i) && (cnt_q[id_rs0_i] == CNT_W'(1));
        wb_clears_rs1 = wb_rf_we_i && (wb_waddr_i == id_rs1_i) && (cnt_q[id_rs1_i] == CNT_W'(1));
`else
        wb_clears_rs0 = 1'b0;
        wb_clears_rs1 = 1'b0;
`endif
        busy_rs0 = (id_rs0_i != '0) && (cnt_q[id_rs0_i] != '0) && !wb_clears_rs0;
        busy_rs1 = (id_rs1_i != '0) && (cnt_q[id_rs1_i] != '0) && !wb_clears_rs1;
        rd_full  = id_rf_we_i && (id_rd_i != '0) && (cnt_q[id_rd_i] == CNT_MAX);
        haz      = id_valid_i && ((id_uses_rs0_i && busy_rs0) || (id_uses_rs1_i && busy_rs1) || rd_full);
    end

    // NOTE: every output gets a default first so no path through the block infers a latch.
    always_comb begin
        issue_o = 1'b0;
        stall_o = 1'b0;
        flush_o = 1'b0;
        if (reset) begin
            if ((state_q == ST_FLUSH) || ex_br_taken_i) begin
                flush_o = 1'b1;
            end else begin
                issue_o = id_valid_i && !haz;
                stall_o = haz;
            end
        end
    end

    // An issue and a writeback to the same register cancel; an underflowing writeback is flagged.
    always_comb begin
        inc      = issue_o && id_rf_we_i && (id_rd_i != '0);
        dec      = wb_rf_we_i && (wb_waddr_i != '0);
        cnt_d    = cnt_q;
        sb_err_d = sb_err_q;
        if (inc && !(dec && (wb_waddr_i == id_rd_i))) begin
            cnt_d[id_rd_i] = cnt_q[id_rd_i] + CNT_W'(1);
        end
        if (dec) begin
            if (cnt_q[wb_waddr_i] == '0) begin
                sb_err_d = 1'b1;
            end else if (!(inc && (wb_waddr_i == id_rd_i))) begin
                cnt_d[wb_waddr_i] = cnt_q[wb_waddr_i] - CNT_W'(1);
            end
        end
        stall_cycles_d = stall_cycles_q;
        if (stall_o && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + PERF_W'(1);
        end
    end

    // NOTE: the counter array is cleared by reset because hazards are evaluated straight from it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q          <= '{default: '0};
            sb_err_q       <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
            cnt_q          <= cnt_d;
            sb_err_q       <= sb_err_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_RUN;
            fc_q    <= '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (ex_br_taken_i && (FLUSH_CYCLES > 1)) begin
                        state_q <= ST_FLUSH;
                        fc_q    <= FC_W'(FLUSH_CYCLES - 1);
                    end
                end
                ST_FLUSH: begin
                    if (fc_q == FC_W'(1)) begin
                        state_q <= ST_RUN;
                    end
                    fc_q <= fc_q - FC_W'(1);
                end
                default: begin
                    state_q <= ST_RUN;
                    fc_q    <= '0;
                end
            endcase
        end
    end

    assign sb_err_o       = sb_err_q;
    assign stall_cycles_o = stall_cycles_q;

endmodule

// File: tb/tb_hazard_scoreboard_ctrl.sv
// Directed, table-driven bench for hazard_scoreboard_ctrl in its default build (WB_BYPASS_EN undefined).
module tb_hazard_scoreboard_ctrl;

    logic        clk;
    logic        reset;
    logic        id_valid_i;
    logic [4:0]  id_rs0_i;
    logic [4:0]  id_rs1_i;
    logic        id_uses_rs0_i;
    logic        id_uses_rs1_i;
    logic [4:0]  id_rd_i;
    logic        id_rf_we_i;
    logic        wb_rf_we_i;
    logic [4:0]  wb_waddr_i;
    logic        ex_br_taken_i;
    logic        issue_o;
    logic        stall_o;
    logic        flush_o;
    logic        sb_err_o;
    logic [31:0] stall_cycles_o;

    int n_vec  = 0;
    int n_fail = 0;

    hazard_scoreboard_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .id_valid_i     (id_valid_i),
        .id_rs0_i       (id_rs0_i),
        .id_rs1_i       (id_rs1_i),
        .id_uses_rs0_i  (id_uses_rs0_i),
        .id_uses_rs1_i  (id_uses_rs1_i),
        .id_rd_i        (id_rd_i),
        .id_rf_we_i     (id_rf_we_i),
        .wb_rf_we_i     (wb_rf_we_i),
        .wb_waddr_i     (wb_waddr_i),
        .ex_br_taken_i  (ex_br_taken_i),
        .issue_o        (issue_o),
        .stall_o        (stall_o),
        .flush_o        (flush_o),
        .sb_err_o       (sb_err_o),
        .stall_cycles_o (stall_cycles_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       valid;
        logic [4:0] rs0;
        logic       u0;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rd;
        logic       we;
        logic       wb_we;
        logic [4:0] wba;
        logic       br;
        logic       e_issue;
        logic       e_stall;
        logic       e_flush;
        logic       e_err;
        int         e_scnt;
        logic       chk_scnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic valid, logic [4:0] rs0, logic u0,
                                logic [4:0] rs1, logic u1, logic [4:0] rd, logic we,
                                logic wb_we, logic [4:0] wba, logic br,
                                logic ei, logic es, logic ef, logic ee, int sc);
        vec_t v;
        v.rst = rst; v.valid = valid; v.rs0 = rs0; v.u0 = u0; v.rs1 = rs1; v.u1 = u1;
        v.rd = rd; v.we = we; v.wb_we = wb_we; v.wba = wba; v.br = br;
        v.e_issue = ei; v.e_stall = es; v.e_flush = ef; v.e_err = ee; v.e_scnt = sc;
        v.chk_scnt = (sc >= 0);
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        @(negedge clk);
        reset         = v.rst;
        id_valid_i    = v.valid;
        id_rs0_i      = v.rs0;
        id_uses_rs0_i = v.u0;
        id_rs1_i      = v.rs1;
        id_uses_rs1_i = v.u1;
        id_rd_i       = v.rd;
        id_rf_we_i    = v.we;
        wb_rf_we_i    = v.wb_we;
        wb_waddr_i    = v.wba;
        ex_br_taken_i = v.br;
        #2;
        check({tag, ".issue"}, 32'(issue_o), 32'(v.e_issue));
        check({tag, ".stall"}, 32'(stall_o), 32'(v.e_stall));
        check({tag, ".flush"}, 32'(flush_o), 32'(v.e_flush));
        check({tag, ".err"},   32'(sb_err_o), 32'(v.e_err));
        if (v.chk_scnt) check({tag, ".stall_cycles"}, stall_cycles_o, 32'(v.e_scnt));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // rst valid rs0 u0 rs1 u1 rd we wbwe wba br | issue stall flush err scnt
        vecs.push_back(mk(0,1, 5,1, 0,0, 5,1, 1,4, 1,  0,0,0,0, 0));  // reset beats branch and WB
        vecs.push_back(mk(1,1, 0,0, 0,0, 5,1, 0,0, 0,  1,0,0,0, 0));  // issue rd=5
        vecs.push_back(mk(1,1, 5,1, 0,0, 0,0, 0,0, 0,  0,1,0,0, 0));  // RAW on 5
        vecs.push_back(mk(1,1, 5,1, 0,0, 0,0, 1,5, 0,  0,1,0,0, 1));  // WB same cycle: still stalled
        vecs.push_back(mk(1,1, 5,1, 0,0, 0,0, 0,0, 0,  1,0,0,0, 2));  // released next cycle
        vecs.push_back(mk(1,1, 0,0, 0,0, 3,1, 0,0, 0,  1,0,0,0, 2));  // cnt3=1
        vecs.push_back(mk(1,1, 0,0, 0,0, 3,1, 0,0, 0,  1,0,0,0, 2));  // cnt3=2
        vecs.push_back(mk(1,1, 0,0, 0,0, 3,1, 0,0, 0,  1,0,0,0, 2));  // cnt3=3 (max)
        vecs.push_back(mk(1,1, 0,0, 0,0, 3,1, 0,0, 0,  0,1,0,0, 2));  // saturation stall
        vecs.push_back(mk(1,1, 0,0, 0,0, 3,1, 1,3, 0,  0,1,0,0, 3));
        vecs.push_back(mk(1,1, 0,0, 0,0, 3,1, 0,0, 0,  1,0,0,0, 4));  // cnt3 back to 3
        vecs.push_back(mk(1,1, 0,0, 3,1, 9,1, 0,0, 1,  0,0,1,0, 4));  // branch over hazard
        vecs.push_back(mk(1,1, 0,0, 3,1, 9,1, 0,0, 1,  0,0,1,0, 4));  // second squash, br ignored
        vecs.push_back(mk(1,1, 0,0, 3,1, 9,0, 0,0, 0,  0,1,0,0, 4));  // hazard returns
        vecs.push_back(mk(1,1, 9,1, 0,0, 0,0, 0,0, 0,  1,0,0,0, 5));  // rd=9 never counted
        vecs.push_back(mk(1,1, 0,0, 0,0, 7,1, 0,0, 0,  1,0,0,0, 5));  // cnt7=1
        vecs.push_back(mk(1,1, 0,0, 0,0, 7,1, 1,7, 0,  1,0,0,0, 5));  // inc+dec on 7: stays 1
        vecs.push_back(mk(1,1, 7,1, 0,0, 0,0, 1,7, 0,  0,1,0,0, 5));  // cnt7 still 1 -> 0
        vecs.push_back(mk(1,1, 7,1, 0,0, 0,0, 0,0, 0,  1,0,0,0, 6));
        vecs.push_back(mk(1,1, 0,0, 0,0, 0,1, 0,0, 0,  1,0,0,0, 6));  // write to x0
        vecs.push_back(mk(1,1, 0,1, 0,1, 0,0, 1,0, 0,  1,0,0,0, 6));  // read x0, WB x0: no err
        vecs.push_back(mk(1,0, 0,0, 0,0, 0,0, 1,4, 0,  0,0,0,0, 6));  // WB to idle reg 4
        vecs.push_back(mk(1,0, 0,0, 0,0, 0,0, 0,0, 0,  0,0,0,1, 6));
        vecs.push_back(mk(1,0, 0,0, 0,0, 0,0, 0,0, 0,  0,0,0,1, 6));  // sticky
        vecs.push_back(mk(1,1, 3,1, 0,0, 0,0, 0,0, 0,  0,1,0,1, 6));  // stall on cnt3
        vecs.push_back(mk(0,1, 3,1, 0,0, 0,0, 0,0, 0,  0,0,0,1, 7));  // reset mid-stall
        vecs.push_back(mk(1,1, 3,1, 0,0, 0,0, 0,0, 0,  1,0,0,0, 0));  // all cleared, RUN

        reset = 1'b0; id_valid_i = 1'b1; id_rs0_i = '0; id_rs1_i = '0;
        id_uses_rs0_i = 1'b0; id_uses_rs1_i = 1'b0; id_rd_i = 5'd1; id_rf_we_i = 1'b1;
        wb_rf_we_i = 1'b0; wb_waddr_i = '0; ex_br_taken_i = 1'b0;
        #2;
        check("pre_reset.issue", 32'(issue_o), 32'd0);
        check("pre_reset.stall", 32'(stall_o), 32'd0);
        check("pre_reset.flush", 32'(flush_o), 32'd0);

        foreach (vecs[i]) run_vec(vecs[i], $sformatf("v%0d", i));

        // Back-to-back branches: a new branch right after the squash window restarts it.
        run_vec(mk(1,1, 0,0, 0,0, 10,1, 0,0, 1,  0,0,1,0, -1), "br_a");
        run_vec(mk(1,1, 0,0, 0,0, 10,1, 0,0, 0,  0,0,1,0, -1), "br_b");
        run_vec(mk(1,1, 0,0, 0,0, 10,1, 0,0, 1,  0,0,1,0, -1), "br_c");
        run_vec(mk(1,1, 0,0, 0,0, 10,1, 0,0, 0,  0,0,1,0, -1), "br_d");
        run_vec(mk(1,1, 10,1, 0,0, 0,0, 0,0, 0,  1,0,0,0, -1), "br_e");

        // RAW release timing: WB lands at k==2, issue must appear exactly at k==3.
        run_vec(mk(1,1, 0,0, 0,0, 12,1, 0,0, 0,  1,0,0,0, -1), "raw_issue");
        for (int k = 0; k < 6; k++) begin
            run_vec(mk(1,1, 0,0, 12,1, 0,0, (k == 2), 5'd12, 0,
                       (k >= 3), (k < 3), 0, 0, -1), $sformatf("raw_k%0d", k));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
